// File: rtl/conv3x3_lane_array.sv
// Eight-lane signed 3x3 convolution behind the column router.
// Each lane slides a 3-column window; results follow two pipeline stages.
module conv3x3_lane_array #(
    parameter int LANES       = 8,
    parameter int DW          = 8,
    parameter int ACCW        = 21,
    parameter int RowBufSize  = 256,
    parameter int RowBufAddrW = $clog2(RowBufSize)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wt_load,
    input  logic [9*DW-1:0]             wt_data,
    input  logic                        start_row,
    input  logic [LANES-1:0]            in_valid,
    input  logic [3*DW*LANES-1:0]       in_map,
    input  logic                        row_done_in,
    output logic [LANES-1:0]            out_valid,
    output logic [ACCW*LANES-1:0]       out_data,
    output logic                        out_row_done,
    output logic                        busy,
    output logic [RowBufAddrW-1:0]      col_cnt
);

    localparam int PW = 2*DW + 1;
    localparam int CW = 3*DW;
    localparam logic [RowBufAddrW-1:0] CNT_MAX = RowBufAddrW'(RowBufSize-1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t                   state_q;
    logic                     flush_q;
    logic [9*DW-1:0]          wt_q;
    logic [CW-1:0]            win_q [LANES][3];
    logic [1:0]               fill_q [LANES];
    logic [LANES-1:0]         fire_q;
    logic signed [PW-1:0]     prod_q [LANES][9];
    logic [LANES-1:0]         s1_valid_q;

    logic [LANES-1:0]         shift;
    logic                     clr_win;
    logic                     leave_flush;
    logic [1:0]               fill_nx [LANES];
    logic signed [PW-1:0]     prod_d [LANES][9];
    logic signed [ACCW-1:0]   acc_d [LANES];

    // Unsigned pixel widened to signed, times signed weight.
    function automatic logic signed [PW-1:0] mul(
        input logic [DW-1:0] pix,
        input logic [DW-1:0] w
    );
        logic signed [PW-1:0] px_s;
        logic signed [PW-1:0] wt_s;
        px_s = {{(PW-DW){1'b0}}, pix};
        wt_s = {{(PW-DW){w[DW-1]}}, w};
        return px_s * wt_s;
    endfunction

    // Row control decode shared by the window, counter and FSM logic.
    always_comb begin
        shift       = (state_q == RUN) ? in_valid : '0;
        clr_win     = start_row && (state_q != FLUSH);
        leave_flush = (state_q == FLUSH) && flush_q;
        for (int i = 0; i < LANES; i++) begin
            fill_nx[i] = (fill_q[i] == 2'd3) ? 2'd3 : fill_q[i] + 2'd1;
        end
    end

    // Products of the current window; k = 3*row + column.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            for (int k = 0; k < 9; k++) begin
                prod_d[i][k] = mul(win_q[i][k%3][DW*(k/3)+:DW],
                                   wt_q[DW*k+:DW]);
            end
        end
    end

    // Sign-extended sum of the registered products.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            acc_d[i] = '0;
            for (int k = 0; k < 9; k++) begin
                acc_d[i] = acc_d[i]
                         + {{(ACCW-PW){prod_q[i][k][PW-1]}}, prod_q[i][k]};
            end
        end
    end

    // Row FSM, kernel register and row-done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            flush_q      <= 1'b0;
            busy         <= 1'b0;
            out_row_done <= 1'b0;
            wt_q         <= '0;
        end else begin
            out_row_done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (wt_load) begin
                        wt_q <= wt_data;
                    end
                    if (start_row) begin
                        state_q <= RUN;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    if (row_done_in) begin
                        state_q <= FLUSH;
                        flush_q <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (!flush_q) begin
                        flush_q      <= 1'b1;
                        out_row_done <= 1'b1;
                    end else begin
                        flush_q <= 1'b0;
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Per-lane sliding windows, fill counters and stage-1 trigger.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fire_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                fill_q[i] <= 2'd0;
                for (int c = 0; c < 3; c++) begin
                    win_q[i][c] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                fire_q[i] <= 1'b0;
                if (clr_win) begin
                    win_q[i][0] <= '0;
                    win_q[i][1] <= '0;
                    if (shift[i]) begin
                        win_q[i][2] <= in_map[CW*i+:CW];
                        fill_q[i]   <= 2'd1;
                    end else begin
                        win_q[i][2] <= '0;
                        fill_q[i]   <= 2'd0;
                    end
                end else if (leave_flush) begin
                    fill_q[i] <= 2'd0;
                end else if (shift[i]) begin
                    win_q[i][0] <= win_q[i][1];
                    win_q[i][1] <= win_q[i][2];
                    win_q[i][2] <= in_map[CW*i+:CW];
                    fill_q[i]   <= fill_nx[i];
                    fire_q[i]   <= (fill_nx[i] == 2'd3);
                end
            end
        end
    end

    // Stage 1: capture the nine products of each firing lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                for (int k = 0; k < 9; k++) begin
                    prod_q[i][k] <= '0;
                end
            end
        end else begin
            s1_valid_q <= fire_q;
            for (int i = 0; i < LANES; i++) begin
                if (fire_q[i]) begin
                    for (int k = 0; k < 9; k++) begin
                        prod_q[i][k] <= prod_d[i][k];
                    end
                end
            end
        end
    end

    // Stage 2: register lane sums and their one-cycle valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= s1_valid_q;
            for (int i = 0; i < LANES; i++) begin
                if (s1_valid_q[i]) begin
                    out_data[ACCW*i+:ACCW] <= acc_d[i];
                end
            end
        end
    end

    // Columns accepted by the last lane this row, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt <= '0;
        end else if (clr_win) begin
            col_cnt <= shift[LANES-1] ? RowBufAddrW'(1) : '0;
        end else if (leave_flush) begin
            col_cnt <= '0;
        end else if (shift[LANES-1] && (col_cnt != CNT_MAX)) begin
            col_cnt <= col_cnt + RowBufAddrW'(1);
        end
    end

endmodule

// File: tb/tb_conv3x3_lane_array.sv
// Bench for conv3x3_lane_array: directed columns with hand-computed results.
// Expected outputs are queued at issue time and checked by a monitor.
module tb_conv3x3_lane_array;

    logic         clk;
    logic         rst;
    logic         wt_load;
    logic [71:0]  wt_data;
    logic         start_row;
    logic [7:0]   in_valid;
    logic [191:0] in_map;
    logic         row_done_in;
    logic [7:0]   out_valid;
    logic [167:0] out_data;
    logic         out_row_done;
    logic         busy;
    logic [7:0]   col_cnt;

    typedef struct {
        logic [7:0] mask;
        int         val;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;
    int   cyc;

    localparam logic [71:0] K_CENTER = 72'h1 << 32;
    localparam logic [71:0] K_ONES   = {9{8'h01}};
    localparam logic [71:0] K_NEG    = {9{8'h80}};

    conv3x3_lane_array dut (
        .clk          (clk),
        .rst          (rst),
        .wt_load      (wt_load),
        .wt_data      (wt_data),
        .start_row    (start_row),
        .in_valid     (in_valid),
        .in_map       (in_map),
        .row_done_in  (row_done_in),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_row_done (out_row_done),
        .busy         (busy),
        .col_cnt      (col_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every presented result must match the head of the queue.
    always @(negedge clk) begin
        if (out_valid != 8'h00) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", longint'(out_valid), 0);
            end else begin
                exp_t e;
                int   bad_lane;
                logic signed [20:0] a;
                e = sb.pop_front();
                chk("out_mask", longint'(out_valid), longint'(e.mask));
                chk("out_latency", cyc, e.cyc);
                bad_lane = -1;
                for (int i = 0; i < 8; i++) begin
                    a = out_data[21*i+:21];
                    if (e.mask[i] && int'(a) != e.val && bad_lane < 0) begin
                        bad_lane = i;
                    end
                end
                if (bad_lane >= 0) begin
                    a = out_data[21*bad_lane+:21];
                    chk($sformatf("out_data_lane%0d", bad_lane),
                        int'(a), e.val);
                end else begin
                    chk("out_data", e.val, e.val + 0 * int'(out_valid));
                end
            end
        end
    end

    function automatic logic [191:0] mkmap(input logic [7:0] t,
                                            input logic [7:0] m,
                                            input logic [7:0] b);
        return {8{b, m, t}};
    endfunction

    task automatic load_w(input logic [71:0] w);
        wt_data = w;
        wt_load = 1'b1;
        @(posedge clk); #1;
        wt_load = 1'b0;
    endtask

    task automatic start();
        start_row = 1'b1;
        @(posedge clk); #1;
        start_row = 1'b0;
    endtask

    task automatic col(input logic sr, input logic [7:0] v,
                       input logic [7:0] t, input logic [7:0] m,
                       input logic [7:0] b, input logic [7:0] emask,
                       input int eval);
        exp_t e;
        start_row = sr;
        in_valid  = v;
        in_map    = mkmap(t, m, b);
        if (emask != 8'h00) begin
            e.mask = emask;
            e.val  = eval;
            e.cyc  = cyc + 3;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start_row = 1'b0;
        in_valid  = 8'h00;
    endtask

    task automatic finish_row();
        row_done_in = 1'b1;
        @(posedge clk); #1;
        row_done_in = 1'b0;
        chk("flush1_busy", busy, 1);
        chk("flush1_row_done", out_row_done, 0);
        @(posedge clk); #1;
        chk("flush2_row_done", out_row_done, 1);
        chk("flush2_busy", busy, 1);
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);
        chk("idle_row_done", out_row_done, 0);
        chk("idle_col_cnt", col_cnt, 0);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b0;
        wt_load     = 1'b0;
        wt_data     = '0;
        start_row   = 1'b0;
        in_valid    = '0;
        in_map      = '0;
        row_done_in = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", (out_data != '0), 0);
        chk("rst_busy", busy, 0);
        chk("rst_row_done", out_row_done, 0);
        chk("rst_col_cnt", col_cnt, 0);
        #9 rst = 1'b0;
        @(posedge clk); #1;

        // Center-tap kernel, mid pixels 10..40; IDLE column ignored.
        load_w(K_CENTER);
        col(0, 8'hFF, 8'd1, 8'd99, 8'd1, 8'h00, 0);
        chk("idle_ignores_col", col_cnt, 0);
        start();
        chk("run_busy", busy, 1);
        col(0, 8'hFF, 0, 10, 0, 8'h00, 0);
        col(0, 8'hFF, 0, 20, 0, 8'h00, 0);
        col(0, 8'hFF, 0, 30, 0, 8'hFF, 20);
        col(0, 8'hFF, 0, 40, 0, 8'hFF, 30);
        chk("col_cnt_4", col_cnt, 4);
        finish_row();

        // All +1 and all -128 kernels on saturated pixels.
        load_w(K_ONES);
        start();
        col(0, 8'hFF, 255, 255, 255, 8'h00, 0);
        col(0, 8'hFF, 255, 255, 255, 8'h00, 0);
        col(0, 8'hFF, 255, 255, 255, 8'hFF, 2295);
        finish_row();
        load_w(K_NEG);
        start();
        col(0, 8'hFF, 255, 255, 255, 8'h00, 0);
        col(0, 8'hFF, 255, 255, 255, 8'h00, 0);
        col(0, 8'hFF, 255, 255, 255, 8'hFF, -293760);
        finish_row();

        // Partial first column, then restart with a column in RUN.
        load_w(K_CENTER);
        start();
        col(0, 8'hFC, 0, 5, 0, 8'h00, 0);
        col(0, 8'hFF, 0, 6, 0, 8'h00, 0);
        col(0, 8'hFF, 0, 7, 0, 8'hFC, 6);
        col(0, 8'hFF, 0, 8, 0, 8'hFF, 7);
        col(1, 8'hFF, 0, 9, 0, 8'h00, 0);
        col(0, 8'hFF, 0, 10, 0, 8'h00, 0);
        col(0, 8'hFF, 0, 11, 0, 8'hFF, 10);
        chk("col_cnt_restart", col_cnt, 3);
        finish_row();

        // Kernel load during RUN is ignored; in IDLE it takes effect.
        start();
        col(0, 8'hFF, 1, 1, 1, 8'h00, 0);
        load_w(K_ONES);
        col(0, 8'hFF, 2, 2, 2, 8'h00, 0);
        col(0, 8'hFF, 3, 3, 3, 8'hFF, 2);
        finish_row();
        load_w(K_ONES);
        start();
        col(0, 8'hFF, 1, 1, 1, 8'h00, 0);
        col(0, 8'hFF, 2, 2, 2, 8'h00, 0);
        col(0, 8'hFF, 3, 3, 3, 8'hFF, 18);
        finish_row();

        // Reset mid-row with a result in flight.
        start();
        col(0, 8'hFF, 0, 4, 0, 8'h00, 0);
        col(0, 8'hFF, 0, 5, 0, 8'h00, 0);
        col(0, 8'hFF, 0, 6, 0, 8'hFF, 15);
        #2 rst = 1'b1;
        sb.delete();
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_data", (out_data != '0), 0);
        chk("abort_busy", busy, 0);
        chk("abort_col_cnt", col_cnt, 0);
        @(posedge clk); #1;
        chk("abort_row_done", out_row_done, 0);
        chk("abort_valid_hold", out_valid, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_busy", busy, 0);
        start();
        col(0, 8'hFF, 200, 200, 200, 8'h00, 0);
        col(0, 8'hFF, 200, 200, 200, 8'h00, 0);
        col(0, 8'hFF, 200, 200, 200, 8'hFF, 0);
        finish_row();

        repeat (6) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
